// File: rtl/floating_point_renormalizer.sv
`default_nettype none
// ============================================================================
// Module      : floating_point_renormalizer
// Description : Back end of the binary32 add datapath. Takes the result sign,
//               the shared exponent and the raw 25-bit mantissa sum,
//               renormalises the sum and packs an IEEE-754 binary32 word.
//               Valid/ready handshakes on the input and output sides; one
//               operation in flight at a time.
//
//               Default build: iterative normalisation, one bit per cycle.
//               Define FP_RENORM_FAST_EN to normalise in a single cycle
//               with a leading-one priority encoder (same results/flags).
//
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               in_valid   - operands valid
//               in_ready   - block idle, can accept
//               sign       - result sign
//               exp        - shared exponent of the aligned operands
//               mant       - mantissa sum (bit 24 carry, bit 23 hidden bit)
//               out_valid  - result valid
//               out_ready  - downstream accepts
//               result     - packed binary32
//               overflow   - carry renormalisation saturated to infinity
//               zero       - result is exact zero
// Revision    : 1.0 - initial release
// ============================================================================
module floating_point_renormalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [24:0] mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        zero
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state;
    logic        sgn;
    logic [24:0] m;
    // Nine bits so the increment out of 254 is seen as 255 rather than wrapping.
    logic [8:0]  e;
    // Input exponent was all ones: pack the operand unchanged.
    logic        pass;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

`ifdef FP_RENORM_FAST_EN
    // Leading-zero count of m[23:0] and the clamped left-shift amount.
    logic [8:0]  lz;
    logic [8:0]  shamt;
    logic [23:0] m_norm;
    logic [8:0]  e_norm;
    logic [8:0]  e_inc;

    always_comb begin
        lz = 9'd24;
        // Ascending scan: the highest set bit is the last to write lz.
        for (int i = 0; i < 24; i++) begin
            if (m[i]) begin
                lz = 9'(23 - i);
            end
        end
        // Never shift the exponent below 1; what remains is subnormal.
        shamt  = (lz > (e - 9'd1)) ? (e - 9'd1) : lz;
        m_norm = m[23:0] << shamt;
        e_norm = e - shamt;
        e_inc  = e + 9'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sgn      <= 1'b0;
            m        <= 25'h0;
            e        <= 9'h0;
            pass     <= 1'b0;
            result   <= 32'h0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sgn      <= sign;
                        m        <= mant;
                        e        <= (exp == 8'h00) ? 9'd1 : {1'b0, exp};
                        pass     <= (exp == 8'hFF);
                        overflow <= 1'b0;
                        zero     <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (pass) begin
                        result <= {sgn, 8'hFF, m[22:0]};
                        state  <= ST_DONE;
                    end else if (m == 25'h0) begin
                        // Exact zero is always +0.
                        result <= 32'h0;
                        zero   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (m[24]) begin
`ifdef FP_RENORM_FAST_EN
                        if (e_inc == 9'd255) begin
                            result   <= {sgn, 8'hFF, 23'h0};
                            overflow <= 1'b1;
                        end else begin
                            result <= {sgn, e_inc[7:0], m[23:1]};
                        end
                        state <= ST_DONE;
`else
                        // Truncating right shift; m[24] is clear afterwards,
                        // so this branch is taken at most once.
                        m <= {1'b0, m[24:1]};
                        e <= e + 9'd1;
                        if (e + 9'd1 == 9'd255) begin
                            result   <= {sgn, 8'hFF, 23'h0};
                            overflow <= 1'b1;
                            state    <= ST_DONE;
                        end
`endif
                    end else begin
`ifdef FP_RENORM_FAST_EN
                        if (m_norm[23]) begin
                            result <= {sgn, e_norm[7:0], m_norm[22:0]};
                        end else begin
                            result <= {sgn, 8'h00, m_norm[22:0]};
                        end
                        state <= ST_DONE;
`else
                        if (m[23]) begin
                            result <= {sgn, e[7:0], m[22:0]};
                            state  <= ST_DONE;
                        end else if (e > 9'd1) begin
                            m <= {m[23:0], 1'b0};
                            e <= e - 9'd1;
                        end else begin
                            // Exponent floor reached without a hidden bit.
                            result <= {sgn, 8'h00, m[22:0]};
                            state  <= ST_DONE;
                        end
`endif
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_floating_point_renormalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_floating_point_renormalizer
// Description : Self-checking bench for floating_point_renormalizer. Directed
//               cases plus randomized operands compared with a value-level
//               reference model (result, flags, latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floating_point_renormalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        zero;

    int errors = 0;
    int checks = 0;

    floating_point_renormalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .exp       (exp),
        .mant      (mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: value-level renormalisation of the operand.
    function automatic void model(input logic s, input logic [7:0] ex, input logic [24:0] mn,
                                  output logic [31:0] res, output logic ov, output logic zr,
                                  output int lat);
        int ee;
        int p;
        int k;
        logic [24:0] mm;
        ov  = 1'b0;
        zr  = 1'b0;
        lat = 1;
        ee  = (ex == 8'h00) ? 1 : int'(ex);
        if (ex == 8'hFF) begin
            res = {s, 8'hFF, mn[22:0]};
        end else if (mn == 25'h0) begin
            res = 32'h0;
            zr  = 1'b1;
        end else if (mn[24]) begin
            ee = ee + 1;
            if (ee == 255) begin
                res = {s, 8'hFF, 23'h0};
                ov  = 1'b1;
            end else begin
                res = {s, 8'(ee), mn[23:1]};
                lat = 2;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (mn[i]) p = i;
            k = 23 - p;
            if (k > ee - 1) k = ee - 1;
            mm  = mn << k;
            ee  = ee - k;
            lat = k + 1;
            res = mm[23] ? {s, 8'(ee), mm[22:0]} : {s, 8'h00, mm[22:0]};
        end
`ifdef FP_RENORM_FAST_EN
        lat = 1;
`endif
    endfunction

    // One complete transaction: drive, measure latency, check, hold, release.
    task automatic run_op(input logic s, input logic [7:0] ex, input logic [24:0] mn,
                          input int hold);
        logic [31:0] w_res;
        logic        w_ov;
        logic        w_zr;
        int          w_lat;
        int          lat;
        logic [31:0] held;
        model(s, ex, mn, w_res, w_ov, w_zr, w_lat);
        @(posedge clk); #1;
        check("ready_before", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        sign     = s;
        exp      = ex;
        mant     = mn;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sign     = ~s;
        exp      = $urandom;
        mant     = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, w_lat);
        check("result", result, w_res);
        check("overflow", {31'h0, overflow}, {31'h0, w_ov});
        check("zero", {31'h0, zero}, {31'h0, w_zr});
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_result", result, held);
            check("hold_in_ready", {31'h0, in_ready}, 32'h0);
            check("hold_valid", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", {31'h0, out_valid}, 32'h0);
        check("release_ready", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sign      = 1'b0;
        exp       = 8'h0;
        mant      = 25'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {30'h0, overflow, zero}, 32'h0);

        // Directed cases.
        run_op(1'b0, 8'h7F, 25'h080_0000, 0);
        run_op(1'b0, 8'h7F, 25'h100_0000, 0);
        run_op(1'b0, 8'h7F, 25'h000_0001, 0);
        run_op(1'b1, 8'h55, 25'h000_0000, 0);
        run_op(1'b0, 8'hFE, 25'h100_0000, 0);
        run_op(1'b0, 8'h02, 25'h020_0000, 5);
        run_op(1'b1, 8'hFF, 25'h1AB_CDEF, 1);
        run_op(1'b0, 8'h00, 25'h040_0001, 0);

        // Reset in the middle of a long normalisation.
        @(posedge clk); #1;
        in_valid = 1'b1;
        exp      = 8'h7F;
        mant     = 25'h000_0001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", {31'h0, out_valid}, 32'h0);
        check("abort_ready", {31'h0, in_ready}, 32'h1);
        run_op(1'b0, 8'h7F, 25'h080_0000, 0);

        // Randomized operands over the interesting classes.
        for (int t = 0; t < 60; t++) begin
            logic [24:0] rm;
            logic [7:0]  re;
            int          cls;
            cls = $urandom_range(0, 9);
            re  = $urandom;
            rm  = $urandom;
            case (cls)
                0: rm = 25'h0;
                1: re = 8'hFF;
                2: begin rm[24] = 1'b1; re = $urandom_range(250, 254); end
                3: re = $urandom_range(0, 3);
                default: rm = rm >> $urandom_range(0, 24);
            endcase
            run_op(1'($urandom), re, rm, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
